// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH..WB and drives datapath selects, strobes and alu_ctrl.
// Optional sticky illegal-instruction trap is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module mc_control_fsm #(
    parameter int DATA_WIDTH     = 32,
    parameter int CONTROLL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      zero,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic                      adr_src,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      reg_write,
    output logic [1:0]                alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [1:0]                result_src,
    output logic [2:0]                imm_src,
    output logic [CONTROLL_WIDTH-1:0] alu_ctrl,
    output logic                      retire,
    output logic                      illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_ILLEGAL
`endif
    } state_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t S_BAD = S_ILLEGAL;
`else
    localparam state_t S_BAD = S_FETCH;
`endif

    localparam logic [CONTROLL_WIDTH-1:0] ALU_ADD = CONTROLL_WIDTH'(0);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_SUB = CONTROLL_WIDTH'(1);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_AND = CONTROLL_WIDTH'(2);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_OR  = CONTROLL_WIDTH'(3);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_XOR = CONTROLL_WIDTH'(4);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_SLT = CONTROLL_WIDTH'(5);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_SLL = CONTROLL_WIDTH'(6);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_SRL = CONTROLL_WIDTH'(7);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_SRA = CONTROLL_WIDTH'(8);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_b30;
    logic       w_unused;

    assign w_op     = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_b30    = instr[30];
    assign w_unused = &{1'b0, instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    // instr[30] selects SUB only for register ops; it always selects SRA over SRL
    function automatic logic [CONTROLL_WIDTH-1:0] alu_op(input logic [2:0] f3, input logic b30,
                                                         input logic is_reg);
        alu_op = ALU_ADD;
        case (f3)
            3'b000: alu_op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLT;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = b30 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
        endcase
    endfunction

    function automatic logic [CONTROLL_WIDTH-1:0] br_op(input logic [2:0] f3);
        br_op = ALU_ADD;
        case (f3)
            3'b001:  br_op = ALU_SUB;
            3'b100:  br_op = ALU_OR;
            3'b101:  br_op = ALU_SLL;
            3'b110:  br_op = ALU_SLT;
            3'b111:  br_op = ALU_AND;
            default: br_op = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = IMM_I;
        alu_ctrl   = ALU_ADD;
        retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (w_op == OP_JAL) ? IMM_J : IMM_B;
                case (w_op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_REG:            w_next = S_EXECR;
                    OP_IMM:            w_next = S_EXECI;
                    OP_BR:             w_next = (w_f3[2:1] == 2'b01) ? S_BAD : S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_BAD;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = w_op[5] ? IMM_S : IMM_I;
                w_next    = w_op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_op(w_f3, w_b30, 1'b1);
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_op(w_f3, w_b30, 1'b0);
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                pc_write  = zero;
                alu_ctrl  = br_op(w_f3);
                w_next    = S_FETCH;
            end
            S_JAL: begin
                pc_write = 1'b1;
                w_next   = S_LINK;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                w_next     = S_LINK;
            end
            S_LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                w_next    = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL: w_next = S_ILLEGAL;
`endif
            default: w_next = S_FETCH;
        endcase
        retire = (w_next == S_FETCH) && (r_state != S_FETCH);
        // an instruction interrupted by reset must not commit anything on the reset edge
        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst)                      r_illegal <= 1'b0;
        else if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle RV32I control unit: sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath muxes, the write strobes and the 4-bit `alu` operation code. It consumes the `alu` `zero` flag for branch resolution. It sits between the instruction register / memory handshake and the shared datapath (PC, IR, register file, ALUOut and data registers), with one `alu` instance reused across all states.

## Interface
- `DATA_WIDTH`, 32, instruction width.
- `CONTROLL_WIDTH`, 4, width of `alu_ctrl`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  DATA_WIDTH  instruction register contents; valid from DECODE onward.
- `zero`  in  1  `alu` flag; sampled only in BRANCH.
- `mem_ready`  in  1  memory completion for the current `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  store enable; only asserted with `mem_req`.
- `adr_src`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  latch fetched word into IR and old PC.
- `pc_write`  out  1  PC update from result bus.
- `reg_write`  out  1  register-file write to `instr[11:7]`.
- `alu_src_a`  out  2  operand A: 00 PC, 01 oldPC, 10 rs1 reg, 11 zero.
- `alu_src_b`  out  2  operand B: 00 rs2 reg, 01 immediate, 10 constant 4.
- `result_src`  out  2  result bus: 00 ALUOut, 01 data reg, 10 live ALU result.
- `imm_src`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_ctrl`  out  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7 SRA=8.
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegal`  out  1  sticky illegal-instruction flag (see Configuration).

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, ILLEGAL.
- Outputs decode from the current state. Strobes not listed for a state are 0. `alu_ctrl` defaults to ADD.
- FETCH: `mem_req`=1, `adr_src`=0, A=00, B=10. `ir_write` and `pc_write` equal `mem_ready`. Stay until `mem_ready`, then go to DECODE.
- DECODE: A=01, B=01. `imm_src` is J for opcode 1101111, otherwise B. ALUOut receives the branch/jump target. Next state by opcode:
  - 0000011 and 0100011 go to MEMADR.
  - 0110011 goes to EXECR; 0010011 goes to EXECI.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL; 1100111 goes to JALR.
  - 0110111 goes to LUI.
  - Any other opcode is illegal.
- MEMADR: A=10, B=01. `imm_src` is I for loads and S for stores. Loads go to MEMREAD; stores go to MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Wait for `mem_ready`, then FETCH.
- EXECR: A=10, B=00. Decode on funct3:
  - 000 gives SUB if `instr[30]`, else ADD.
  - 001 SLL; 010 and 011 SLT; 100 XOR.
  - 101 gives SRA if `instr[30]`, else SRL.
  - 110 OR; 111 AND.
  - Next state: ALUWB.
- EXECI: same decode with B=01 and `imm_src`=I. funct3 000 is always ADD; `instr[30]` is used only for 101. Next state: ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, then FETCH.
- BRANCH: A=10, B=00, `result_src`=00, `pc_write`=`zero`. Taken when `zero`=1.
  - funct3 mapping: 000 ADD, 001 SUB, 100 OR, 101 SLL, 110 SLT, 111 AND.
  - funct3 010 and 011 are illegal.
  - Next state: FETCH.
- JAL: `result_src`=00, `pc_write`=1, then LINK.
- JALR: A=10, B=01, `imm_src`=I, `result_src`=10, `pc_write`=1, then LINK.
- LINK: A=01, B=10, `result_src`=10, `reg_write`=1, then FETCH.
- LUI: A=11, B=01, `imm_src`=U, then ALUWB.
- `retire` is 1 when the next state is FETCH from any non-FETCH state.

## Timing
- Reset: state becomes FETCH and `illegal`=0.
- While `rst`=1, `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write` and `retire` are forced to 0.
- Reset asserted mid-instruction abandons it; no write strobe fires on that edge.
- Cycle counts with `mem_ready` tied to 1:
  - R, I, LUI, store, JAL, JALR: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
- Each cycle with `mem_ready`=0 adds one cycle in FETCH, MEMREAD or MEMWRITE. Outputs are held stable during the wait.
- `pc_write` and `reg_write` are never asserted together in the same cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode or branch funct3 sends DECODE to ILLEGAL.
  - ILLEGAL sets `illegal`=1, drives all strobes 0 and holds until `rst`.
- Not defined:
  - Illegal encodings go from DECODE to FETCH as a NOP, with `retire`=1.
  - `illegal` is tied to 0 and no ILLEGAL state exists.

## Test plan
- `add` (0x002081B3) with `mem_ready`=1 -> 4 cycles. EXECR `alu_ctrl`=0; ALUWB `reg_write`=1; single `retire` pulse.
- `sub` (0x402081B3) then `srai` (0x4020D193) -> EXECR `alu_ctrl`=1; EXECI `alu_ctrl`=8 with `imm_src`=000.
- `lw` with `mem_ready` low for 2 cycles in MEMREAD -> 7 cycles total. `mem_req`=1 and `adr_src`=1 held throughout; MEMWB `result_src`=01.
- `bge` (funct3 101) with `zero`=1, then with `zero`=0 -> `alu_ctrl`=6 in both cases; `pc_write`=1 then 0; 3 cycles each.
- `jalr` -> JALR `pc_write`=1 with `result_src`=10, then LINK `reg_write`=1 with A=01 and B=10.
- Opcode 0x7F, with and without `CTRL_ILLEGAL_TRAP_EN` -> defined: `illegal`=1 and stuck until `rst`. Undefined: back in FETCH after 2 cycles with `retire`=1.
